// File: rtl/ins_miss_queue.sv
// ins_miss_queue: instruction-cache miss line-address FIFO feeding the
// next-level cache over a valid/ready handshake, with issued/merged/dropped
// statistics counters.
// Optional feature macro: INS_MISS_COALESCE_EN -- coalesce a miss whose
// address matches the most recently enqueued entry still held.
module ins_miss_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     miss_valid,
  input  logic [AW-1:0]            miss_addr,
  output logic                     miss_ready,
  output logic                     l2_valid,
  output logic [AW-1:0]            l2_addr,
  input  logic                     l2_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              issued,
  output logic [31:0]              merged,
  output logic [31:0]              dropped
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          not_full;
  logic          deq;
  logic          acc;
  logic          drop;
  logic          merge;

  assign not_full   = occupancy < (PW+1)'(DEPTH);
  assign l2_valid   = (occupancy != '0);
  assign l2_addr    = mem[rd_ptr];
  assign deq        = l2_valid && l2_ready;
  assign miss_ready = not_full || deq;
  assign acc        = miss_valid && miss_ready && !merge;
  assign drop       = miss_valid && !miss_ready && !merge;

`ifdef INS_MISS_COALESCE_EN
  logic [PW-1:0] last_ptr;

  // Match against the newest entry; an entry leaving this cycle still counts.
  assign last_ptr = wr_ptr - PW'(1);
  assign merge    = miss_valid && (occupancy != '0) && (miss_addr == mem[last_ptr]);

  // Count coalesced misses; cleared by reset and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merged <= '0;
    end else if (flush) begin
      merged <= '0;
    end else if (merge) begin
      merged <= merged + 32'd1;
    end
  end
`else
  assign merge  = 1'b0;
  assign merged = '0;
`endif

  // Storage write; contents are never reset, pointers alone define validity.
  always_ff @(posedge clk) begin
    if (acc && !flush) begin
      mem[wr_ptr] <= miss_addr;
    end
  end

  // Pointers, occupancy and issued/dropped counters; flush overrides all events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      issued    <= '0;
      dropped   <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      issued    <= '0;
      dropped   <= '0;
    end else begin
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
        issued <= issued + 32'd1;
      end
      if (acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (drop) begin
        dropped <= dropped + 32'd1;
      end
      case ({acc, deq})
        2'b10:   occupancy <= occupancy + (PW+1)'(1);
        2'b01:   occupancy <= occupancy - (PW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_miss_queue.sv
// Directed self-checking bench for ins_miss_queue (DEPTH=4, AW=26).
module tb_ins_miss_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        miss_valid;
  logic [25:0] miss_addr;
  logic        miss_ready;
  logic        l2_valid;
  logic [25:0] l2_addr;
  logic        l2_ready;
  logic [2:0]  occupancy;
  logic [31:0] issued;
  logic [31:0] merged;
  logic [31:0] dropped;

  int unsigned total;
  int unsigned bad;

  ins_miss_queue #(.DEPTH(4), .AW(26)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .l2_valid   (l2_valid),
    .l2_addr    (l2_addr),
    .l2_ready   (l2_ready),
    .occupancy  (occupancy),
    .issued     (issued),
    .merged     (merged),
    .dropped    (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [25:0] a);
    miss_valid = 1'b1;
    miss_addr  = a;
    tick();
    miss_valid = 1'b0;
  endtask

  logic [25:0] exp_q [4];
  int unsigned cnt;
  int unsigned exp_iss;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; flush = 1'b0; miss_valid = 1'b0; miss_addr = '0; l2_ready = 1'b0;
    #12;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_valid", 32'(l2_valid), 0);
    chk("rst_issued", issued, 0);
    chk("rst_merged", merged, 0);
    chk("rst_dropped", dropped, 0);
    rst_n = 1'b1;
    tick();

    // Single enqueue then issue.
    l2_ready = 1'b1;
    miss_valid = 1'b1; miss_addr = 26'h0000123;
    #1 chk("t1_ready", 32'(miss_ready), 1);
    tick();
    miss_valid = 1'b0;
    chk("t1_valid", 32'(l2_valid), 1);
    chk("t1_addr", 32'(l2_addr), 32'h123);
    chk("t1_occ1", 32'(occupancy), 1);
    tick();
    chk("t1_issued", issued, 1);
    chk("t1_occ0", 32'(occupancy), 0);
    chk("t1_empty", 32'(l2_valid), 0);

    // Fill to DEPTH with l2 stalled; the fifth miss is dropped.
    l2_ready = 1'b0;
    exp_q[0] = 26'h10; exp_q[1] = 26'h20; exp_q[2] = 26'h30; exp_q[3] = 26'h40;
    for (int i = 0; i < 4; i++) begin
      miss_valid = 1'b1; miss_addr = exp_q[i];
      #1 chk("t2_ready_fill", 32'(miss_ready), 1);
      tick();
    end
    miss_valid = 1'b1; miss_addr = 26'h50;
    #1 chk("t2_ready_full", 32'(miss_ready), 0);
    tick();
    miss_valid = 1'b0;
    chk("t2_occ_full", 32'(occupancy), 4);
    chk("t2_dropped", dropped, 1);
    chk("t2_head", 32'(l2_addr), 32'h10);
    tick();
    chk("t2_hold_valid", 32'(l2_valid), 1);
    chk("t2_hold_addr", 32'(l2_addr), 32'h10);
    l2_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_valid", 32'(l2_valid), 1);
      chk("t2_drain_addr", 32'(l2_addr), 32'(exp_q[i]));
      tick();
    end
    chk("t2_occ_empty", 32'(occupancy), 0);
    chk("t2_issued", issued, 5);

    // Full queue: simultaneous dequeue and accept.
    l2_ready = 1'b0;
    exp_q[0] = 26'h200; exp_q[1] = 26'h300; exp_q[2] = 26'h400; exp_q[3] = 26'h500;
    strobe(26'h100); strobe(26'h200); strobe(26'h300); strobe(26'h400);
    chk("t3_occ_full", 32'(occupancy), 4);
    l2_ready = 1'b1;
    miss_valid = 1'b1; miss_addr = 26'h500;
    #1 chk("t3_ready_bypass", 32'(miss_ready), 1);
    tick();
    miss_valid = 1'b0;
    chk("t3_occ_stays", 32'(occupancy), 4);
    chk("t3_no_drop", dropped, 1);
    chk("t3_issued", issued, 6);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_addr", 32'(l2_addr), 32'(exp_q[i]));
      tick();
    end
    chk("t3_issued_end", issued, 10);
    chk("t3_occ_empty", 32'(occupancy), 0);

    // Repeated address back-to-back.
    l2_ready = 1'b0;
    strobe(26'h0AA);
    strobe(26'h0AA);
`ifdef INS_MISS_COALESCE_EN
    chk("t4_occ", 32'(occupancy), 1);
    chk("t4_merged", merged, 1);
    exp_iss = 11;
`else
    chk("t4_occ", 32'(occupancy), 2);
    chk("t4_merged", merged, 0);
    exp_iss = 12;
`endif
    l2_ready = 1'b1;
    cnt = 0;
    while (l2_valid && cnt < 8) begin
      chk("t4_drain_addr", 32'(l2_addr), 32'h0AA);
      tick();
      cnt++;
    end
    chk("t4_drain_bound", 32'(l2_valid), 0);
    chk("t4_issued", issued, exp_iss);

    // Flush with a same-cycle miss and handshake.
    l2_ready = 1'b0;
    strobe(26'h1); strobe(26'h2); strobe(26'h3);
    chk("t5_occ3", 32'(occupancy), 3);
    flush = 1'b1; miss_valid = 1'b1; miss_addr = 26'h4; l2_ready = 1'b1;
    tick();
    flush = 1'b0; miss_valid = 1'b0;
    chk("t5_occ", 32'(occupancy), 0);
    chk("t5_issued", issued, 0);
    chk("t5_merged", merged, 0);
    chk("t5_dropped", dropped, 0);
    tick();
    chk("t5_valid", 32'(l2_valid), 0);

    // Asynchronous reset between edges with two entries held.
    l2_ready = 1'b0;
    strobe(26'h6); strobe(26'h7); strobe(26'h8);
    l2_ready = 1'b1;
    tick();
    l2_ready = 1'b0;
    chk("t6_occ2", 32'(occupancy), 2);
    chk("t6_issued1", issued, 1);
    chk("t6_head", 32'(l2_addr), 32'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(l2_valid), 0);
    chk("t6_occ", 32'(occupancy), 0);
    chk("t6_issued", issued, 0);
    chk("t6_dropped", dropped, 0);
    chk("t6_merged", merged, 0);
    #3 rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ins_miss_queue.md
# ins_miss_queue

Buffers instruction-cache miss line addresses on their way to the next-level cache. Sits directly downstream of the instruction cache: it captures each 26-bit line address (address bits [31:6]) that the cache emits on a miss, queues it in a small FIFO, and presents it to the next-level cache over a valid/ready handshake. Keeps issued/merged/dropped statistics for the statistics module, and clears them on the trace RESET command.

## Interface
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two and at least 2.
- `AW`, default 26: line-address width.

- `clk`  in  1  single clock for the block; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear, driven when the trace command is RESET (n=8).
- `miss_valid`  in  1  the instruction cache presents a miss line address this cycle.
- `miss_addr`  in  AW  the miss line address.
- `miss_ready`  out  1  combinational; the entry will be accepted this cycle.
- `l2_valid`  out  1  the queue head is valid.
- `l2_addr`  out  AW  the queue head address.
- `l2_ready`  in  1  the next-level cache accepts the head.
- `occupancy`  out  $clog2(DEPTH)+1  number of entries currently held.
- `issued`  out  32  count of completed l2 handshakes.
- `merged`  out  32  count of coalesced misses.
- `dropped`  out  32  count of misses lost because the queue was full.

## Operation
- Storage is a circular FIFO with a read pointer, a write pointer and an occupancy counter. Pointers are log2(DEPTH) bits wide and wrap naturally.
- Dequeue: `deq = l2_valid && l2_ready`. On dequeue the read pointer advances and `issued` increments.
- Accept: `acc = miss_valid && (occupancy < DEPTH || deq) && !merge`. On accept, `miss_addr` is written at the write pointer and the write pointer advances.
- `miss_ready = (occupancy < DEPTH) || deq`. This is combinational from `l2_ready`.
- Drop: `miss_valid && !miss_ready && !merge`. The entry is discarded and `dropped` increments.
- Occupancy update:
  - +1 on accept without dequeue.
  - −1 on dequeue without accept.
  - Unchanged when both or neither occur.
- When full, a dequeue and an accept in the same cycle are both honoured. Occupancy stays at DEPTH and nothing is dropped.
- Outputs derive from registered state:
  - `l2_valid = (occupancy != 0)`.
  - `l2_addr` is the entry at the read pointer.
  - When `l2_valid` is 0, `l2_addr` is don't-care.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0 silently.
- `flush` has priority over every same-cycle event. At the edge it:
  - sets both pointers, `occupancy`, `issued`, `merged` and `dropped` to 0;
  - discards the same-cycle miss, which is not counted;
  - does not count a same-cycle handshake as issued.
- Reset values (`rst_n` low, asynchronous):
  - pointers, `occupancy`, `issued`, `merged`, `dropped` = 0;
  - `l2_valid` = 0.
  - Storage contents are not reset.
- Reset asserted mid-operation abandons all queued entries immediately, without waiting for a clock edge.

## Timing
- Enqueue-to-issue latency is 1 cycle: an address accepted at edge k is visible on `l2_addr` with `l2_valid`=1 after edge k, provided the queue was empty.
- An accepted entry cannot appear on `l2_addr` in the same cycle it is accepted (there is no bypass path).
- Sustained throughput is one accept plus one issue per cycle.
- `l2_valid` must stay high and `l2_addr` must stay stable until a handshake completes.
- The upstream side does not hold its request on a stall: `miss_valid` is a one-cycle strobe, and a miss that is not accepted is dropped, not retried.

## Configuration
- Macro: `INS_MISS_COALESCE_EN`.
- Defined:
  - `merge = miss_valid && occupancy != 0 && miss_addr == entry[wr_ptr-1]`, i.e. a match against the most recently enqueued entry still held.
  - A merged miss is not stored and `merged` increments.
  - Merge takes precedence over drop, so a matching miss arriving while the queue is full counts as merged, not dropped.
  - An entry being dequeued in the same cycle is still a valid match.
- Not defined:
  - `merge` is constant 0 and `merged` is tied to 0.
  - Every miss is either enqueued or dropped.

## Test plan
- Reset, then enqueue 0x0000123 with `l2_ready`=1 → the next cycle shows `l2_valid`=1, `l2_addr`=0x0000123; the cycle after shows `issued`=1 and `occupancy`=0.
- Hold `l2_ready`=0 and strobe 5 distinct addresses with `DEPTH`=4 → `occupancy`=4, `miss_ready`=0 on the 5th, `dropped`=1. Then release → the 4 addresses issue in order, one per cycle.
- Full queue, `l2_ready`=1 and a new miss in the same cycle → the miss is accepted, `occupancy` stays at 4, `dropped`=0.
- With `INS_MISS_COALESCE_EN` and `l2_ready`=0, strobe 0x00000AA twice → `occupancy`=1, `merged`=1. Without the macro → `occupancy`=2, `merged`=0.
- Fill 3 entries, then assert `flush` together with `miss_valid` and a handshake → after the edge all counters are 0 and `occupancy`=0; the next cycle shows `l2_valid`=0.
- Drop `rst_n` asynchronously between edges with 2 entries held → `l2_valid` falls immediately and all counters read 0.
